// File: rtl/parking_space_manager.sv
// rtl/parking_space_manager.sv - parking occupancy map with entry/exit request handshakes
module parking_space_manager #(
    parameter logic [7:0] INIT_MAP = 8'hFF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enter_req,
    input  logic [2:0] enter_number,
    input  logic       exit_req,
    input  logic [2:0] exit_number,
    output logic [7:0] parking_capacity,
    output logic       park_enable,
    output logic [3:0] free_count,
    output logic       full,
    output logic       empty,
    output logic       enter_ack,
    output logic       enter_err,
    output logic       exit_ack,
    output logic       exit_err,
    output logic       busy
);
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) c = c + {3'd0, v[i]};
        return c;
    endfunction

    localparam logic [3:0] INIT_COUNT = popcount8(INIT_MAP);

    typedef enum logic [1:0] {IDLE, EXIT_OP, ENTER_OP, ACK_WAIT} state_t;

    state_t     state;
    logic [2:0] number_q;
    logic       pending_exit;
    logic [7:0] map_next;
    logic [3:0] count_next;

    // Only an accepted operation touches the map; status flags follow the same next values.
    always_comb begin
        map_next   = parking_capacity;
        count_next = free_count;
        if (state == EXIT_OP && !parking_capacity[number_q]) begin
            map_next[number_q] = 1'b1;
            count_next         = free_count + 4'd1;
        end else if (state == ENTER_OP && parking_capacity[number_q]) begin
            map_next[number_q] = 1'b0;
            count_next         = free_count - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            number_q         <= 3'd0;
            pending_exit     <= 1'b0;
            parking_capacity <= INIT_MAP;
            free_count       <= INIT_COUNT;
            full             <= (INIT_COUNT == 4'd0);
            empty            <= (INIT_COUNT == 4'd8);
            park_enable      <= |INIT_MAP;
            enter_ack        <= 1'b0;
            enter_err        <= 1'b0;
            exit_ack         <= 1'b0;
            exit_err         <= 1'b0;
            busy             <= 1'b0;
        end else begin
            parking_capacity <= map_next;
            free_count       <= count_next;
            full             <= (count_next == 4'd0);
            empty            <= (count_next == 4'd8);
            park_enable      <= |map_next;
            enter_ack        <= 1'b0;
            exit_ack         <= 1'b0;
            case (state)
                IDLE: begin
                    // Exit wins a tie because it frees capacity.
                    if (exit_req) begin
                        number_q     <= exit_number;
                        pending_exit <= 1'b1;
                        state        <= EXIT_OP;
                        busy         <= 1'b1;
                    end else if (enter_req) begin
                        number_q     <= enter_number;
                        pending_exit <= 1'b0;
                        state        <= ENTER_OP;
                        busy         <= 1'b1;
                    end
                end
                EXIT_OP: begin
                    exit_ack <= 1'b1;
                    exit_err <= parking_capacity[number_q];
                    state    <= ACK_WAIT;
                end
                ENTER_OP: begin
                    enter_ack <= 1'b1;
                    enter_err <= !parking_capacity[number_q];
                    state     <= ACK_WAIT;
                end
                ACK_WAIT: begin
                    if (pending_exit ? !exit_req : !enter_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_parking_space_manager.sv
// tb/tb_parking_space_manager.sv - randomized bench with occupancy model for parking_space_manager
module tb_parking_space_manager;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       enter_req, exit_req;
    logic [2:0] enter_number, exit_number;
    logic [7:0] parking_capacity;
    logic       park_enable, full, empty, busy;
    logic [3:0] free_count;
    logic       enter_ack, enter_err, exit_ack, exit_err;

    parking_space_manager #(.INIT_MAP(8'hFF)) dut (
        .clk(clk), .reset_n(reset_n),
        .enter_req(enter_req), .enter_number(enter_number),
        .exit_req(exit_req), .exit_number(exit_number),
        .parking_capacity(parking_capacity), .park_enable(park_enable),
        .free_count(free_count), .full(full), .empty(empty),
        .enter_ack(enter_ack), .enter_err(enter_err),
        .exit_ack(exit_ack), .exit_err(exit_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_map = 8'hFF;
    logic       exp_enter_ack = 1'b0;
    logic       exp_exit_ack = 1'b0;
    logic       cmp_en = 1'b0;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int free_spaces(input logic [7:0] m);
        int c = 0;
        for (int i = 0; i < 8; i++) if (m[i]) c++;
        return c;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("map", parking_capacity, exp_map);
            chk("free_count", 8'(free_count), 8'(free_spaces(exp_map)));
            chk("full", 8'(full), 8'(exp_map == 8'h00));
            chk("empty", 8'(empty), 8'(exp_map == 8'hFF));
            chk("park_enable", 8'(park_enable), 8'(exp_map != 8'h00));
            chk("enter_ack", 8'(enter_ack), 8'(exp_enter_ack));
            chk("exit_ack", 8'(exit_ack), 8'(exp_exit_ack));
        end
    end

    // Applies the model effect of one acknowledged request and checks ack/err at the ack edge.
    task automatic model_ack(input bit is_exit, input logic [2:0] n);
        logic e_err;
        e_err = is_exit ? exp_map[n] : !exp_map[n];
        if (is_exit) begin
            chk("exit_ack_edge", 8'(exit_ack), 8'd1);
            chk("exit_err", 8'(exit_err), 8'(e_err));
            exp_exit_ack = 1'b1;
            if (!e_err) exp_map[n] = 1'b1;
        end else begin
            chk("enter_ack_edge", 8'(enter_ack), 8'd1);
            chk("enter_err", 8'(enter_err), 8'(e_err));
            exp_enter_ack = 1'b1;
            if (!e_err) exp_map[n] = 1'b0;
        end
    endtask

    task automatic single(input bit is_exit, input logic [2:0] n);
        @(negedge clk);
        if (is_exit) begin exit_req = 1'b1; exit_number = n; end
        else begin enter_req = 1'b1; enter_number = n; end
        @(posedge clk); #1;
        chk("busy_op", 8'(busy), 8'd1);
        @(posedge clk); #1;
        model_ack(is_exit, n);
        @(negedge clk);
        exit_req = 1'b0; enter_req = 1'b0;
        @(posedge clk); #1;
        exp_exit_ack = 1'b0; exp_enter_ack = 1'b0;
        chk("busy_idle", 8'(busy), 8'd0);
    endtask

    task automatic both(input logic [2:0] xn, input logic [2:0] en);
        @(negedge clk);
        exit_req = 1'b1; exit_number = xn; enter_req = 1'b1; enter_number = en;
        @(posedge clk); #1;
        chk("busy_both", 8'(busy), 8'd1);
        @(posedge clk); #1;
        model_ack(1'b1, xn);
        @(negedge clk);
        exit_req = 1'b0;
        @(posedge clk); #1;
        exp_exit_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_ack(1'b0, en);
        @(negedge clk);
        enter_req = 1'b0;
        @(posedge clk); #1;
        exp_enter_ack = 1'b0;
        chk("busy_idle2", 8'(busy), 8'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        enter_req = 1'b0; exit_req = 1'b0;
        enter_number = 3'd0; exit_number = 3'd0;
        #12;
        chk("rst_map", parking_capacity, 8'hFF);
        chk("rst_count", 8'(free_count), 8'd8);
        chk("rst_empty", 8'(empty), 8'd1);
        chk("rst_full", 8'(full), 8'd0);
        chk("rst_pe", 8'(park_enable), 8'd1);
        chk("rst_busy", 8'(busy), 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cmp_en = 1'b1;

        for (int i = 0; i < 8; i++) begin
            logic [7:0] lit;
            lit = 8'hFF << (i + 1);
            single(1'b0, 3'(i));
            chk("fill_map", parking_capacity, lit);
            chk("fill_err", 8'(enter_err), 8'd0);
        end
        chk("full_lit", 8'(full), 8'd1);
        chk("full_pe", 8'(park_enable), 8'd0);
        chk("full_count", 8'(free_count), 8'd0);

        single(1'b0, 3'd3);
        chk("enter_full_err", 8'(enter_err), 8'd1);
        chk("enter_full_map", parking_capacity, 8'h00);
        single(1'b1, 3'd5);
        chk("exit5_map", parking_capacity, 8'h20);
        chk("exit5_count", 8'(free_count), 8'd1);

        for (int i = 0; i < 8; i++) single(1'b1, 3'(i));
        chk("refill_map", parking_capacity, 8'hFF);
        single(1'b1, 3'd2);
        chk("exit_free_err", 8'(exit_err), 8'd1);
        chk("exit_free_map", parking_capacity, 8'hFF);
        single(1'b0, 3'd0);
        chk("fe_map", parking_capacity, 8'hFE);
        single(1'b0, 3'd0);
        chk("enter_occ_err", 8'(enter_err), 8'd1);
        chk("enter_occ_map", parking_capacity, 8'hFE);

        for (int i = 4; i < 8; i++) single(1'b0, 3'(i));
        single(1'b1, 3'd0);
        chk("map_0f", parking_capacity, 8'h0F);
        both(3'd6, 3'd0);
        chk("both_map", parking_capacity, 8'h4E);
        chk("both_count", 8'(free_count), 8'd4);

        // Reset while an entry sits in ACK_WAIT with its request still held.
        @(negedge clk);
        enter_req = 1'b1; enter_number = 3'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_ack(1'b0, 3'd1);
        cmp_en = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_map", parking_capacity, 8'hFF);
        chk("mid_rst_count", 8'(free_count), 8'd8);
        chk("mid_rst_ack", 8'(enter_ack), 8'd0);
        chk("mid_rst_busy", 8'(busy), 8'd0);
        chk("mid_rst_err", 8'(enter_err), 8'd0);
        enter_req = 1'b0;
        exp_map = 8'hFF; exp_enter_ack = 1'b0; exp_exit_ack = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cmp_en = 1'b1;
        repeat (4) @(posedge clk);

        for (int t = 0; t < 150; t++) begin
            int kind;
            kind = $urandom_range(0, 2);
            if (kind == 0) single(1'b0, 3'($urandom_range(0, 7)));
            else if (kind == 1) single(1'b1, 3'($urandom_range(0, 7)));
            else both(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
